// File: rtl/bus_copy_engine_if.sv
// -----------------------------------------------------------------------------
// bus_copy_engine_if
// Single-master request/ready/valid memory bus. The copy engine drives it as
// the initiator; block RAMs and peripherals sit on the target side.
//
// Signals:
//   request  initiator -> target  access request, held until ready is seen
//   rw       initiator -> target  0 = read, 1 = write
//   address  initiator -> target  byte address
//   wdata    initiator -> target  write data
//   rdata    target -> initiator  read data, valid with ready during a read
//   ready    target -> initiator  acknowledge, high while request is held
//   valid    target -> initiator  address-in-range flag, sampled with ready
// -----------------------------------------------------------------------------
interface bus_copy_engine_if #(
  parameter int WIDTH = 32
) ();
  logic             request;
  logic             rw;
  logic [31:0]      address;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             ready;
  logic             valid;

  modport master (
    output request, rw, address, wdata,
    input  rdata, ready, valid
  );

  modport slave (
    input  request, rw, address, wdata,
    output rdata, ready, valid
  );
endinterface

// File: rtl/bus_copy_engine.sv
// -----------------------------------------------------------------------------
// bus_copy_engine
// Word-copy bus initiator. A start strobe latches source, destination and
// word count; the engine then reads one word and writes it back out, one bus
// access at a time, until the count is exhausted or the target flags an
// out-of-range address (abort).
//
// Optional feature macro: BUS_COPY_ENGINE_FILL_EN
//   When defined, i_fill / i_pattern are added. With i_fill=1 the read phase
//   is skipped and i_pattern is written to every destination word.
//
// Ports:
//   i_clock      sole clock, rising edge
//   i_reset_n    asynchronous active-low reset
//   i_start      one-cycle start strobe, honoured only while idle
//   i_src/i_dst  source / destination byte addresses, captured on start
//   i_count      words to copy, captured on start
//   i_fill       (FILL_EN only) pattern-fill select, captured on start
//   i_pattern    (FILL_EN only) fill word, captured on start
//   o_busy       high from accepted start until return to idle
//   o_done       one-cycle pulse on completion or abort
//   o_error      sticky error, cleared on next accepted start
//   o_remaining  words not yet fully written
//   bus          initiator side of the memory bus
// -----------------------------------------------------------------------------
module bus_copy_engine #(
  parameter int WIDTH     = 32,
  parameter int CNT_W     = 16,
  parameter int ADDR_STEP = 4
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_start,
  input  logic [31:0]         i_src,
  input  logic [31:0]         i_dst,
  input  logic [CNT_W-1:0]    i_count,
`ifdef BUS_COPY_ENGINE_FILL_EN
  input  logic                i_fill,
  input  logic [WIDTH-1:0]    i_pattern,
`endif
  output logic                o_busy,
  output logic                o_done,
  output logic                o_error,
  output logic [CNT_W-1:0]    o_remaining,
  bus_copy_engine_if.master   bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_REQ = 3'd1,
    ST_RD_REL = 3'd2,
    ST_WR_REQ = 3'd3,
    ST_WR_REL = 3'd4
  } state_t;

  state_t             state_r, state_s;
  logic [31:0]        src_r, src_s, dst_r, dst_s;
  logic [31:0]        src_inc_s, dst_inc_s;
  logic [CNT_W-1:0]   rem_r, rem_s, rem_dec_s;
  logic [WIDTH-1:0]   buf_r, buf_s;
  logic               err_r, err_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;
  logic               zero_pend_r, zero_pend_s;
  logic               req_r, req_s;
  logic               rw_r, rw_s;
  logic [31:0]        addr_r, addr_s;
  logic [WIDTH-1:0]   wdata_r, wdata_s;
`ifdef BUS_COPY_ENGINE_FILL_EN
  logic               fill_r, fill_s;
  logic [WIDTH-1:0]   pattern_r, pattern_s;
`endif

  assign src_inc_s = src_r + 32'(ADDR_STEP);
  assign dst_inc_s = dst_r + 32'(ADDR_STEP);
  assign rem_dec_s = rem_r - {{(CNT_W-1){1'b0}}, 1'b1};

  // Next-state and next-output logic; bus outputs are computed for the state
  // being entered so they are registered and stable across each REQ state.
  always_comb begin
    state_s     = state_r;
    src_s       = src_r;
    dst_s       = dst_r;
    rem_s       = rem_r;
    buf_s       = buf_r;
    err_s       = err_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
    zero_pend_s = 1'b0;
    req_s       = 1'b0;
    rw_s        = rw_r;
    addr_s      = addr_r;
    wdata_s     = wdata_r;
`ifdef BUS_COPY_ENGINE_FILL_EN
    fill_s      = fill_r;
    pattern_s   = pattern_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (zero_pend_r) begin
          // zero-length job: finish one cycle after the accepted start
          done_s = 1'b1;
          busy_s = 1'b0;
        end else if (i_start) begin
          src_s  = i_src;
          dst_s  = i_dst;
          rem_s  = i_count;
          err_s  = 1'b0;
          busy_s = 1'b1;
`ifdef BUS_COPY_ENGINE_FILL_EN
          fill_s    = i_fill;
          pattern_s = i_pattern;
`endif
          if (i_count == {CNT_W{1'b0}}) begin
            zero_pend_s = 1'b1;
`ifdef BUS_COPY_ENGINE_FILL_EN
          end else if (i_fill) begin
            state_s = ST_WR_REQ;
            req_s   = 1'b1;
            rw_s    = 1'b1;
            addr_s  = i_dst;
            wdata_s = i_pattern;
`endif
          end else begin
            state_s = ST_RD_REQ;
            req_s   = 1'b1;
            rw_s    = 1'b0;
            addr_s  = i_src;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_RD_REQ: begin
        if (bus.ready) begin
          buf_s   = bus.rdata;
          err_s   = err_r | ~bus.valid;
          state_s = ST_RD_REL;
        end else begin
          req_s = 1'b1;
        end
      end

      ST_RD_REL: begin
        // never raise the next request while the target still holds ready
        if (!bus.ready) begin
          if (err_r) begin
            state_s = ST_IDLE;
            done_s  = 1'b1;
            busy_s  = 1'b0;
          end else begin
            state_s = ST_WR_REQ;
            req_s   = 1'b1;
            rw_s    = 1'b1;
            addr_s  = dst_r;
            wdata_s = buf_r;
          end
        end else begin
          state_s = ST_RD_REL;
        end
      end

      ST_WR_REQ: begin
        if (bus.ready) begin
          err_s   = err_r | ~bus.valid;
          state_s = ST_WR_REL;
        end else begin
          req_s = 1'b1;
        end
      end

      ST_WR_REL: begin
        if (!bus.ready) begin
          if (err_r) begin
            // failed word stays counted in remaining
            state_s = ST_IDLE;
            done_s  = 1'b1;
            busy_s  = 1'b0;
          end else begin
            src_s = src_inc_s;
            dst_s = dst_inc_s;
            rem_s = rem_dec_s;
            if (rem_dec_s == {CNT_W{1'b0}}) begin
              state_s = ST_IDLE;
              done_s  = 1'b1;
              busy_s  = 1'b0;
`ifdef BUS_COPY_ENGINE_FILL_EN
            end else if (fill_r) begin
              state_s = ST_WR_REQ;
              req_s   = 1'b1;
              rw_s    = 1'b1;
              addr_s  = dst_inc_s;
              wdata_s = pattern_r;
`endif
            end else begin
              state_s = ST_RD_REQ;
              req_s   = 1'b1;
              rw_s    = 1'b0;
              addr_s  = src_inc_s;
            end
          end
        end else begin
          state_s = ST_WR_REL;
        end
      end

      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and registered output register
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      src_r       <= 32'd0;
      dst_r       <= 32'd0;
      rem_r       <= {CNT_W{1'b0}};
      buf_r       <= {WIDTH{1'b0}};
      err_r       <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      zero_pend_r <= 1'b0;
      req_r       <= 1'b0;
      rw_r        <= 1'b0;
      addr_r      <= 32'd0;
      wdata_r     <= {WIDTH{1'b0}};
`ifdef BUS_COPY_ENGINE_FILL_EN
      fill_r      <= 1'b0;
      pattern_r   <= {WIDTH{1'b0}};
`endif
    end else begin
      src_r       <= src_s;
      dst_r       <= dst_s;
      rem_r       <= rem_s;
      buf_r       <= buf_s;
      err_r       <= err_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      zero_pend_r <= zero_pend_s;
      req_r       <= req_s;
      rw_r        <= rw_s;
      addr_r      <= addr_s;
      wdata_r     <= wdata_s;
`ifdef BUS_COPY_ENGINE_FILL_EN
      fill_r      <= fill_s;
      pattern_r   <= pattern_s;
`endif
    end
  end

  assign o_busy      = busy_r;
  assign o_done      = done_r;
  assign o_error     = err_r;
  assign o_remaining = rem_r;
  assign bus.request = req_r;
  assign bus.rw      = rw_r;
  assign bus.address = addr_r;
  assign bus.wdata   = wdata_r;

endmodule

// File: tb/tb_bus_copy_engine.sv
// -----------------------------------------------------------------------------
// tb_bus_copy_engine
// Directed bench for bus_copy_engine against a small memory target model.
// Read data is a fixed function of the word index (0x60 + index), so source
// words at 0x100.. read as 0xA0, 0xA1, ...; writes land in a separate array.
// Addresses at or above 0x400 are reported out of range.
// Fill-mode vectors run when BUS_COPY_ENGINE_FILL_EN is defined.
// -----------------------------------------------------------------------------
module tb_bus_copy_engine;
  localparam int WIDTH = 32;
  localparam int CNT_W = 16;

  logic             i_clock = 1'b0;
  logic             i_reset_n;
  logic             i_start;
  logic [31:0]      i_src;
  logic [31:0]      i_dst;
  logic [CNT_W-1:0] i_count;
`ifdef BUS_COPY_ENGINE_FILL_EN
  logic             i_fill;
  logic [WIDTH-1:0] i_pattern;
`endif
  logic             o_busy;
  logic             o_done;
  logic             o_error;
  logic [CNT_W-1:0] o_remaining;

  bus_copy_engine_if #(.WIDTH(WIDTH)) bus ();

  bus_copy_engine #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ADDR_STEP(4)) dut (
    .i_clock     (i_clock),
    .i_reset_n   (i_reset_n),
    .i_start     (i_start),
    .i_src       (i_src),
    .i_dst       (i_dst),
    .i_count     (i_count),
`ifdef BUS_COPY_ENGINE_FILL_EN
    .i_fill      (i_fill),
    .i_pattern   (i_pattern),
`endif
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_error     (o_error),
    .o_remaining (o_remaining),
    .bus         (bus)
  );

  always #5 i_clock = ~i_clock;

  // target model
  int          extra_hold;
  int          hold_r;
  logic        clr_mem;
  logic [31:0] wmem [256];

  assign bus.rdata = 32'h60 + {24'd0, bus.address[9:2]};
  assign bus.valid = (bus.address < 32'h400);

  always @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      bus.ready <= 1'b0;
      hold_r    <= 0;
    end else begin
      if (clr_mem) begin
        for (int i = 0; i < 256; i++) wmem[i] <= 32'h0;
      end
      if (bus.request && bus.ready && bus.rw && bus.valid)
        wmem[bus.address[9:2]] <= bus.wdata;
      if (bus.request) begin
        bus.ready <= 1'b1;
        hold_r    <= extra_hold;
      end else if (hold_r > 0) begin
        hold_r <= hold_r - 1;
      end else begin
        bus.ready <= 1'b0;
      end
    end
  end

  // bus monitor: request launches, and launches while ready is still high
  logic req_q   = 1'b0;
  int   viol    = 0;
  int   rd_reqs = 0;
  int   all_reqs = 0;
  always @(posedge i_clock) begin
    req_q <= bus.request;
    if (bus.request && !req_q) begin
      all_reqs <= all_reqs + 1;
      if (bus.ready) viol <= viol + 1;
      if (!bus.rw) rd_reqs <= rd_reqs + 1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // pulse start; returns #1 after the edge that samples it (edge S)
  task automatic start_copy(input logic [31:0] src, input logic [31:0] dst, input logic [CNT_W-1:0] cnt);
    @(posedge i_clock); #1;
    i_src   = src;
    i_dst   = dst;
    i_count = cnt;
    i_start = 1'b1;
    @(posedge i_clock); #1;
    i_start = 1'b0;
  endtask

  // counts edges after S until o_done is seen, bounded by budget
  task automatic wait_done(input string tag, input int budget, output int cycles);
    cycles = 0;
    while (!o_done && cycles < budget) begin
      @(posedge i_clock); #1;
      cycles++;
    end
    check_val({tag, "_done_seen"}, o_done, 1'b1);
  endtask

  int cyc;
  int r0;
  int a0;

  initial begin
    i_reset_n  = 1'b0;
    i_start    = 1'b0;
    i_src      = 32'h0;
    i_dst      = 32'h0;
    i_count    = '0;
    clr_mem    = 1'b0;
    extra_hold = 0;
`ifdef BUS_COPY_ENGINE_FILL_EN
    i_fill     = 1'b0;
    i_pattern  = 32'h0;
`endif
    @(negedge i_clock);
    check_val("rst_request", bus.request, 1'b0);
    check_val("rst_address", bus.address, 32'h0);
    check_val("rst_busy",    o_busy,      1'b0);
    check_val("rst_done",    o_done,      1'b0);
    check_val("rst_remain",  o_remaining, 16'h0);
    @(negedge i_clock);
    i_reset_n = 1'b1;
    @(posedge i_clock); #1; clr_mem = 1'b1;
    @(posedge i_clock); #1; clr_mem = 1'b0;

    // plain 4-word copy
    r0 = rd_reqs;
    start_copy(32'h100, 32'h200, 16'd4);
    wait_done("copy4", 100, cyc);
    check_val("copy4_cycles", cyc,          32);
    check_val("copy4_error",  o_error,      1'b0);
    check_val("copy4_remain", o_remaining,  16'd0);
    check_val("copy4_busy",   o_busy,       1'b0);
    check_val("copy4_w0",     wmem[128],    32'hA0);
    check_val("copy4_w1",     wmem[129],    32'hA1);
    check_val("copy4_w2",     wmem[130],    32'hA2);
    check_val("copy4_w3",     wmem[131],    32'hA3);
    check_val("copy4_reads",  rd_reqs - r0, 4);
    @(posedge i_clock); #1;
    check_val("copy4_done_pulse", o_done, 1'b0);

    // zero-length job
    a0 = all_reqs;
    start_copy(32'h100, 32'h200, 16'd0);
    check_val("zero_busy_s",  o_busy,      1'b1);
    check_val("zero_req",     bus.request, 1'b0);
    wait_done("zero", 10, cyc);
    check_val("zero_cycles",  cyc,    1);
    check_val("zero_busy_s1", o_busy, 1'b0);
    @(posedge i_clock); #1;
    check_val("zero_done_pulse", o_done, 1'b0);
    check_val("zero_no_reqs", all_reqs - a0, 0);

    // second read falls out of range
    start_copy(32'h3FC, 32'h300, 16'd3);
    wait_done("oor", 100, cyc);
    check_val("oor_cycles", cyc,         12);
    check_val("oor_error",  o_error,     1'b1);
    check_val("oor_remain", o_remaining, 16'd2);
    check_val("oor_busy",   o_busy,      1'b0);
    check_val("oor_w0",     wmem[192],   32'h15F);
    check_val("oor_w1",     wmem[193],   32'h0);

    // slow target holds ready 3 extra cycles after release
    extra_hold = 3;
    start_copy(32'h100, 32'h280, 16'd2);
    wait_done("slow", 200, cyc);
    check_val("slow_cycles", cyc,       28);
    check_val("slow_error",  o_error,   1'b0);
    check_val("slow_w0",     wmem[160], 32'hA0);
    check_val("slow_w1",     wmem[161], 32'hA1);
    check_val("slow_viol",   viol,      0);
    extra_hold = 0;
    repeat (6) @(posedge i_clock);

    // reset during WR_REQ of word 2 (edges S+12..S+14)
    start_copy(32'h100, 32'h380, 16'd4);
    repeat (12) @(posedge i_clock);
    #1;
    check_val("mid_req",   bus.request, 1'b1);
    check_val("mid_rw",    bus.rw,      1'b1);
    check_val("mid_addr",  bus.address, 32'h384);
    check_val("mid_wdata", bus.wdata,   32'hA1);
    #2 i_reset_n = 1'b0;
    #1;
    check_val("mid_rst_req",    bus.request, 1'b0);
    check_val("mid_rst_rw",     bus.rw,      1'b0);
    check_val("mid_rst_addr",   bus.address, 32'h0);
    check_val("mid_rst_wdata",  bus.wdata,   32'h0);
    check_val("mid_rst_busy",   o_busy,      1'b0);
    check_val("mid_rst_remain", o_remaining, 16'h0);
    check_val("mid_rst_error",  o_error,     1'b0);
    check_val("mid_w0",         wmem[224],   32'hA0);
    check_val("mid_w1",         wmem[225],   32'h0);
    @(negedge i_clock);
    i_reset_n = 1'b1;
    start_copy(32'h100, 32'h3C0, 16'd1);
    wait_done("post", 50, cyc);
    check_val("post_cycles", cyc,         8);
    check_val("post_w0",     wmem[240],   32'hA0);
    check_val("post_remain", o_remaining, 16'd0);
    check_val("post_error",  o_error,     1'b0);

`ifdef BUS_COPY_ENGINE_FILL_EN
    // pattern fill, no reads
    r0        = rd_reqs;
    i_fill    = 1'b1;
    i_pattern = 32'hDEADBEEF;
    start_copy(32'h3FC, 32'h40, 16'd5);
    i_fill    = 1'b0;
    wait_done("fill", 100, cyc);
    check_val("fill_cycles", cyc,          20);
    check_val("fill_reads",  rd_reqs - r0, 0);
    check_val("fill_error",  o_error,      1'b0);
    for (int i = 16; i <= 20; i++) check_val("fill_word", wmem[i], 32'hDEADBEEF);
    check_val("fill_after", wmem[21], 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bus_copy_engine.md
# bus_copy_engine

Word-copy bus initiator: on a start strobe it reads a block of words from a source address and writes them to a destination address, one access at a time, over the single-master request/ready/valid memory bus used by the codebase's block RAMs and peripherals. It is the initiating end of that bus and sits between a CPU-side control register file and a memory/peripheral target. It offloads bulk moves such as framebuffer blits and buffer clears.

## Interface
- WIDTH, 32: data word width.
- CNT_W, 16: width of the word-count input and remaining counter.
- ADDR_STEP, 4: byte increment applied to both addresses per word.
- i_clock  in  1  sole clock, rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_start  in  1  one-cycle start strobe, honoured only while idle.
- i_src  in  32  source byte address, captured on start.
- i_dst  in  32  destination byte address, captured on start.
- i_count  in  CNT_W  number of words to copy, captured on start.
- o_busy  out  1  high from accepted start until return to idle.
- o_done  out  1  one-cycle pulse on completion or abort.
- o_error  out  1  sticky error, cleared on next accepted start.
- o_remaining  out  CNT_W  words not yet fully written.
- o_request  out  1  bus request.
- o_rw  out  1  0 = read, 1 = write.
- o_address  out  32  bus byte address.
- o_wdata  out  WIDTH  bus write data.
- i_rdata  in  WIDTH  bus read data, valid when i_ready high during a read.
- i_ready  in  1  target acknowledge; stays high while o_request is held, falls after release.
- i_valid  in  1  target address-in-range flag, sampled with i_ready.

## Operation
- States: IDLE, RD_REQ, RD_REL, WR_REQ, WR_REL.
- IDLE: o_request=0. On i_start: latch src/dst/count, clear o_error, o_busy=1; count=0 → stay IDLE, pulse o_done next cycle, no bus traffic; else → RD_REQ.
- RD_REQ: o_request=1, o_rw=0, o_address=src. On i_ready=1: capture i_rdata into word buffer; if i_valid=0 set o_error; → RD_REL.
- RD_REL: o_request=0. Wait i_ready=0; then abort if o_error (→ IDLE, pulse o_done), else → WR_REQ.
- WR_REQ: o_request=1, o_rw=1, o_address=dst, o_wdata=buffer. On i_ready=1: if i_valid=0 set o_error; → WR_REL.
- WR_REL: o_request=0. Wait i_ready=0; then src+=ADDR_STEP, dst+=ADDR_STEP, remaining-=1; remaining reaches 0 or o_error → IDLE with o_done pulse; else → RD_REQ.
- o_address/o_rw/o_wdata stay stable for the whole of each REQ state.
- A new request is never raised while i_ready is still high (release-wait rule).
- Addresses wrap modulo 2^32; no boundary checks beyond i_valid.
- i_start while busy is ignored.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE, o_request=0, o_rw=0, o_address=0, o_wdata=0, o_busy=0, o_done=0, o_error=0, o_remaining=0.
- Against a target that raises ready one cycle after request: each access takes 4 cycles (REQ 2 + REL 2); one word takes 8 cycles.
- Start sampled at edge S: o_request high from S; o_done high during the cycle after edge S+8N; o_busy falls together with the o_done pulse.
- count=0: o_done high during the cycle after S+1.
- Reset mid-transfer: o_request drops immediately; the target sees a truncated access, and the partially written destination is not restored.
- o_remaining decrements only on write completion; after an abort it shows the words left, including the failed one.

## Configuration
- BUS_COPY_ENGINE_FILL_EN defined: adds inputs i_fill (1) and i_pattern (WIDTH), both latched on start. With i_fill=1, RD_REQ/RD_REL are skipped (IDLE → WR_REQ, WR_REL → WR_REQ) and the pattern is written each word. Timing is 4 cycles per word, and src is ignored.
- Undefined: ports absent, and copy-only behaviour as above.

## Test plan
- src=0x100, dst=0x200, count=4, BRAM target preloaded 0xA0..0xA3 → dst words equal 0xA0..0xA3, done at S+32, error=0, remaining=0.
- count=0 → no o_request ever, o_done single pulse at S+1, busy high for one cycle.
- src at last in-range word, count=3 → first read valid, second read i_valid=0 → error=1, done pulse, one destination word written, remaining=2.
- Target holding ready 3 extra cycles per access → copy still correct, no request raised while ready is high, and the cycle count grows to match.
- Reset asserted in WR_REQ of word 2 → o_request low same cycle, all outputs at reset values; the next start runs normally.
- FILL_EN: fill=1, pattern=0xDEADBEEF, count=5, dst=0x40 → 0x40..0x50 hold pattern, zero read requests, done at S+20.
